dram_mem_master: RTL

- Initiator-side controller for the dummy DRAM's `mem_req`/`mem_ready` port.
- Takes single-beat load/store requests from the cache controller and drives one DRAM transaction per request.
- For a store, it packs `{valid, tag, data}` into the DRAM write word. For a load, it captures the DRAM's registered read data.
- Returns one response pulse per request. Sits between the cache controller's miss/writeback path and the DRAM.

---
 rtl/dram_mem_pkg.sv | 9 +
 rtl/mem_timeout_ctr.sv | 18 +
 rtl/dram_mem_master.sv | 91 +++++++++
 3 files changed

// File: rtl/dram_mem_pkg.sv
// dram_mem_pkg: shared FSM states, LSU opcodes and write-word layout helper
package dram_mem_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RDATA, ST_RESP} state_t;
   localparam logic LSU_LW = 1'b0;
   localparam logic LSU_SW = 1'b1;
   function automatic int valid_bit_pos(input int tag_w, input int data_w);
      return tag_w + data_w;
   endfunction
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: saturating stall counter, flags when TIMEOUT stalls have elapsed
module mem_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en && r_cnt != W'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
   assign o_expired = r_cnt == W'(TIMEOUT);
endmodule

// File: rtl/dram_mem_master.sv
// dram_mem_master: single-outstanding load/store master for the DRAM mem_req/mem_ready port.
// Define MEM_TIMEOUT_EN to abandon requests stalled for TIMEOUT cycles with resp_err.
module dram_mem_master
   import dram_mem_pkg::*;
#(
   parameter int TAG     = 20,
   parameter int DATA    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [TAG-1:0]        req_tag,
   input  logic [DATA-1:0]       req_wdata,
   output logic                  resp_valid,
   output logic [DATA-1:0]       resp_rdata,
   output logic                  resp_err,
   output logic                  mem_req,
   input  logic                  mem_ready,
   output logic [31:0]           address,
   output logic                  lsu_operator,
   output logic [TAG+DATA:0]     write_data_int,
   input  logic [DATA-1:0]       dram_data_out
);
   localparam int VP = valid_bit_pos(TAG, DATA);
   state_t            r_state;
   logic [31:0]       r_addr;
   logic              r_we;
   logic [TAG+DATA:0] r_wword;
   logic [DATA-1:0]   r_rdata;
   logic              r_err;
   logic              w_expired;
`ifdef MEM_TIMEOUT_EN
   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (r_state == ST_IDLE),
      .i_en      (r_state == ST_REQ && !mem_ready),
      .o_expired (w_expired)
   );
`else
   assign w_expired = TIMEOUT < 0;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_we    <= LSU_LW;
         r_wword <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE:
               if (req_valid) begin
                  r_state         <= ST_REQ;
                  r_addr          <= req_addr;
                  r_we            <= req_we;
                  r_wword[VP]     <= 1'b1;
                  r_wword[VP-1:0] <= {req_tag, req_wdata};
               end
            ST_REQ:
               if (mem_ready) begin
                  r_state <= r_we == LSU_SW ? ST_RESP : ST_RDATA;
                  r_err   <= 1'b0;
                  if (r_we == LSU_SW) r_rdata <= '0;
               end else if (w_expired) begin
                  r_state <= ST_RESP;
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end
            ST_RDATA: begin
               r_state <= ST_RESP;
               r_rdata <= dram_data_out;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   // state resets asynchronously, so mem_req drops the moment rst asserts
   assign req_ready      = rst && r_state == ST_IDLE;
   assign mem_req        = r_state == ST_REQ;
   assign resp_valid     = r_state == ST_RESP;
   assign resp_rdata     = r_rdata;
   assign resp_err       = r_err;
   assign address        = r_addr;
   assign lsu_operator   = r_we;
   assign write_data_int = r_wword;
endmodule
